// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with a single-outstanding req/ack data-memory port and MEM/WB register.
// Latency: non-memory ops 1 cycle; memory ops 1 issue cycle + bus wait, write-back on the ack edge.
// Backpressure: stall_out (combinational) freezes upstream while an access is issuing or waiting for dm_ack.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   wen_in, mem_write_in, mem_read_in,
//   mem_to_reg_in, jal_in              control from the EXE/MEM register
//   rdata2_in, result_in               store data, ALU result / memory address
//   waddr_in, PC_jal_in                destination register, link address
//   dm_req, dm_we, dm_addr, dm_wdata   data-memory request (held stable until ack)
//   dm_rdata, dm_ack                   read data and one-cycle completion strobe
//   stall_out                          upstream freeze
//   wen_out, waddr_out, wb_data_out    registered MEM/WB payload
//   err_out                            registered one-cycle bus-timeout pulse
//
// Optional feature: define MEM_TIMEOUT_EN to abandon an access after TIMEOUT_CYCLES
// wait cycles without dm_ack. Without it, WAIT lasts until dm_ack and err_out is 0.

`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef ISIZE
`define ISIZE 32
`endif

module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wen_in,
   input  logic              mem_write_in,
   input  logic              mem_read_in,
   input  logic              mem_to_reg_in,
   input  logic              jal_in,
   input  logic [`DSIZE-1:0] rdata2_in,
   input  logic [`DSIZE-1:0] result_in,
   input  logic [`ASIZE-1:0] waddr_in,
   input  logic [`ISIZE-1:0] PC_jal_in,
   output logic              dm_req,
   output logic              dm_we,
   output logic [`DSIZE-1:0] dm_addr,
   output logic [`DSIZE-1:0] dm_wdata,
   input  logic [`DSIZE-1:0] dm_rdata,
   input  logic              dm_ack,
   output logic              stall_out,
   output logic              wen_out,
   output logic [`ASIZE-1:0] waddr_out,
   output logic [`DSIZE-1:0] wb_data_out,
   output logic              err_out
);

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mem_access_stage: TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic                dm_req_q, dm_req_d;
   logic                dm_we_q, dm_we_d;
   logic [`DSIZE-1:0]   dm_addr_q, dm_addr_d;
   logic [`DSIZE-1:0]   dm_wdata_q, dm_wdata_d;
   logic                wen_out_q, wen_out_d;
   logic [`ASIZE-1:0]   waddr_out_q, waddr_out_d;
   logic [`DSIZE-1:0]   wb_data_q, wb_data_d;
   // Write-back fields of the instruction in flight; the address doubles as its ALU result.
   logic                h_wen_q, h_wen_d;
   logic [`ASIZE-1:0]   h_waddr_q, h_waddr_d;
   logic                h_m2r_q, h_m2r_d;
   logic                h_jal_q, h_jal_d;
   logic [`ISIZE-1:0]   h_pc_q, h_pc_d;

   logic                mem_op;
   logic                timeout_hit;
   logic                stall_c;

   // jal has priority over a load result.
   function automatic logic [`DSIZE-1:0] wb_sel(input logic              jal,
                                                input logic [`ISIZE-1:0] pc,
                                                input logic              m2r,
                                                input logic [`DSIZE-1:0] rdata,
                                                input logic [`DSIZE-1:0] alu);
      if (jal)      return `DSIZE'(pc);
      else if (m2r) return rdata;
      else          return alu;
   endfunction

   // A read+write combination is issued as a write.
   assign mem_op = mem_read_in | mem_write_in;

`ifdef MEM_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   assign timeout_hit = (state_q == S_WAIT) && (cnt_q == 8'(TIMEOUT_CYCLES));

   always_comb begin
      cnt_d = cnt_q;
      err_d = 1'b0;
      if (state_q == S_IDLE) begin
         if (mem_op) cnt_d = 8'd0;
      end else if (!dm_ack) begin
         // ack on the timeout edge completes normally, so it suppresses the error.
         if (timeout_hit) err_d = 1'b1;
         else             cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_out = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_out     = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      dm_req_d    = dm_req_q;
      dm_we_d     = dm_we_q;
      dm_addr_d   = dm_addr_q;
      dm_wdata_d  = dm_wdata_q;
      wen_out_d   = wen_out_q;
      waddr_out_d = waddr_out_q;
      wb_data_d   = wb_data_q;
      h_wen_d     = h_wen_q;
      h_waddr_d   = h_waddr_q;
      h_m2r_d     = h_m2r_q;
      h_jal_d     = h_jal_q;
      h_pc_d      = h_pc_q;
      stall_c     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               stall_c    = 1'b1;
               state_d    = S_WAIT;
               dm_req_d   = 1'b1;
               dm_we_d    = mem_write_in;
               dm_addr_d  = result_in;
               dm_wdata_d = rdata2_in;
               wen_out_d  = 1'b0;
               h_wen_d    = wen_in;
               h_waddr_d  = waddr_in;
               h_m2r_d    = mem_to_reg_in;
               h_jal_d    = jal_in;
               h_pc_d     = PC_jal_in;
            end else begin
               wen_out_d   = wen_in;
               waddr_out_d = waddr_in;
               wb_data_d   = wb_sel(jal_in, PC_jal_in, mem_to_reg_in, dm_rdata, result_in);
            end
         end
         S_WAIT: begin
            // Release upstream on the timeout edge too, so the failed access is dropped
            // instead of being reissued from a still-frozen EXE/MEM register.
            stall_c = ~(dm_ack | timeout_hit);
            if (dm_ack) begin
               state_d     = S_IDLE;
               dm_req_d    = 1'b0;
               wen_out_d   = h_wen_q;
               waddr_out_d = h_waddr_q;
               wb_data_d   = wb_sel(h_jal_q, h_pc_q, h_m2r_q, dm_rdata, dm_addr_q);
            end else if (timeout_hit) begin
               state_d   = S_IDLE;
               dm_req_d  = 1'b0;
               wen_out_d = 1'b0;
            end else begin
               wen_out_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stall_out = rst_n & stall_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         dm_req_q    <= 1'b0;
         dm_we_q     <= 1'b0;
         dm_addr_q   <= '0;
         dm_wdata_q  <= '0;
         wen_out_q   <= 1'b0;
         waddr_out_q <= '0;
         wb_data_q   <= '0;
         h_wen_q     <= 1'b0;
         h_waddr_q   <= '0;
         h_m2r_q     <= 1'b0;
         h_jal_q     <= 1'b0;
         h_pc_q      <= '0;
      end else begin
         state_q     <= state_d;
         dm_req_q    <= dm_req_d;
         dm_we_q     <= dm_we_d;
         dm_addr_q   <= dm_addr_d;
         dm_wdata_q  <= dm_wdata_d;
         wen_out_q   <= wen_out_d;
         waddr_out_q <= waddr_out_d;
         wb_data_q   <= wb_data_d;
         h_wen_q     <= h_wen_d;
         h_waddr_q   <= h_waddr_d;
         h_m2r_q     <= h_m2r_d;
         h_jal_q     <= h_jal_d;
         h_pc_q      <= h_pc_d;
      end
   end

   assign dm_req      = dm_req_q;
   assign dm_we       = dm_we_q;
   assign dm_addr     = dm_addr_q;
   assign dm_wdata    = dm_wdata_q;
   assign wen_out     = wen_out_q;
   assign waddr_out   = waddr_out_q;
   assign wb_data_out = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wen_in = 0, mem_write_in = 0, mem_read_in = 0, mem_to_reg_in = 0, jal_in = 0;
   logic [31:0] rdata2_in = '0, result_in = '0, PC_jal_in = '0, dm_rdata = '0;
   logic [4:0]  waddr_in = '0;
   logic        dm_ack = 1'b0;
   logic        dm_req, dm_we, stall_out, wen_out, err_out;
   logic [31:0] dm_addr, dm_wdata, wb_data_out;
   logic [4:0]  waddr_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .wen_in(wen_in), .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
      .mem_to_reg_in(mem_to_reg_in), .jal_in(jal_in),
      .rdata2_in(rdata2_in), .result_in(result_in), .waddr_in(waddr_in), .PC_jal_in(PC_jal_in),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .stall_out(stall_out), .wen_out(wen_out), .waddr_out(waddr_out),
      .wb_data_out(wb_data_out), .err_out(err_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: write-back value of a retiring instruction.
   function automatic logic [31:0] wb_model(input bit jal, input logic [31:0] pc, input bit m2r,
                                            input logic [31:0] rd, input logic [31:0] res);
      if (jal) return pc;
      if (m2r) return rd;
      return res;
   endfunction

   task automatic drive(input bit rd, input bit wr, input bit m2r, input bit jal, input bit wen,
                        input logic [4:0] wa, input logic [31:0] res, input logic [31:0] st,
                        input logic [31:0] pc);
      mem_read_in = rd; mem_write_in = wr; mem_to_reg_in = m2r; jal_in = jal; wen_in = wen;
      waddr_in = wa; result_in = res; rdata2_in = st; PC_jal_in = pc;
   endtask

   // One instruction through the stage; dly = wait cycles before the ack cycle.
   task automatic run_op(input bit rd, input bit wr, input bit m2r, input bit jal, input bit wen,
                         input logic [4:0] wa, input logic [31:0] res, input logic [31:0] st,
                         input logic [31:0] pc, input logic [31:0] rdat, input int dly);
      bit mem;
      int stalls;
      mem = rd | wr;
      stalls = 0;
      @(negedge clk);
      drive(rd, wr, m2r, jal, wen, wa, res, st, pc);
      dm_ack = 1'b0;
      #1;
      chk("issue_stall", stall_out, mem);
      chk("issue_req_idle", dm_req, 0);
      if (!mem) begin
         @(posedge clk); #1;
         chk("alu_wen", wen_out, wen);
         chk("alu_waddr", waddr_out, wa);
         chk("alu_wb", wb_data_out, wb_model(jal, pc, m2r, dm_rdata, res));
         chk("alu_req", dm_req, 0);
         chk("alu_err", err_out, 0);
         return;
      end
      if (stall_out) stalls++;
      @(posedge clk); #1;
      chk("req_up", dm_req, 1);
      chk("req_we", dm_we, wr);
      chk("req_addr", dm_addr, res);
      if (wr) chk("req_wdata", dm_wdata, st);
      chk("req_bubble", wen_out, 0);
      for (int k = 0; k < dly; k++) begin
         @(negedge clk); #1;
         if (stall_out) stalls++;
         @(posedge clk); #1;
         chk("wait_req", dm_req, 1);
         chk("wait_addr", dm_addr, res);
         chk("wait_we", dm_we, wr);
         chk("wait_wen", wen_out, 0);
         chk("wait_err", err_out, 0);
      end
      @(negedge clk);
      dm_ack = 1'b1;
      dm_rdata = rdat;
      #1;
      chk("ack_stall", stall_out, 0);
      @(posedge clk); #1;
      dm_ack = 1'b0;
      dm_rdata = $urandom;
      chk("stall_cycles", stalls, dly + 1);
      chk("done_req", dm_req, 0);
      chk("done_wen", wen_out, wen);
      chk("done_waddr", waddr_out, wa);
      chk("done_wb", wb_data_out, wb_model(jal, pc, m2r, rdat, res));
      chk("done_err", err_out, 0);
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_req", dm_req, 0);
      chk("rst_we", dm_we, 0);
      chk("rst_addr", dm_addr, 0);
      chk("rst_wdata", dm_wdata, 0);
      chk("rst_wen", wen_out, 0);
      chk("rst_waddr", waddr_out, 0);
      chk("rst_wb", wb_data_out, 0);
      chk("rst_err", err_out, 0);
      mem_read_in = 1'b1;
      #1;
      chk("rst_stall", stall_out, 0);
      mem_read_in = 1'b0;
      #20;
      rst_n = 1'b1;

      // ALU op
      run_op(0, 0, 0, 0, 1, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 0);
      // Load with three wait cycles
      run_op(1, 0, 1, 0, 1, 5'd7, 32'h40, 32'h0, 32'h0, 32'hDEAD_BEEF, 3);
      // Store with one wait cycle
      run_op(0, 1, 0, 0, 0, 5'd0, 32'h80, 32'hA5A5_A5A5, 32'h0, 32'h0, 1);
      // Read+write treated as a write
      run_op(1, 1, 0, 0, 0, 5'd3, 32'h84, 32'h1357_9BDF, 32'h0, 32'h0, 0);
      // jal has priority over mem_to_reg
      run_op(0, 0, 1, 1, 1, 5'd31, 32'h55, 32'h0, 32'h0000_0104, 32'h0, 0);
      // Back-to-back loads, immediate ack
      run_op(1, 0, 1, 0, 1, 5'd1, 32'h100, 32'h0, 32'h0, 32'h1111_2222, 0);
      run_op(1, 0, 1, 0, 1, 5'd2, 32'h104, 32'h0, 32'h0, 32'h3333_4444, 0);

      // Randomized instruction stream
      for (int i = 0; i < 40; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         case (kind)
            0: run_op(0, 0, 0, 0, 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom, 0);
            1: run_op(1, 0, 1, 0, 1, 5'($urandom), $urandom, $urandom, $urandom, $urandom,
                      $urandom_range(0, 4));
            2: run_op(1'($urandom), 1, 0, 0, 0, 5'($urandom), $urandom, $urandom, $urandom, $urandom,
                      $urandom_range(0, 4));
            default: run_op(0, 0, 1'($urandom), 1, 1, 5'($urandom), $urandom, $urandom, $urandom,
                            $urandom, 0);
         endcase
      end

`ifdef MEM_TIMEOUT_EN
      // No ack: abandoned after four wait cycles
      @(negedge clk);
      drive(1, 0, 1, 0, 1, 5'd9, 32'h200, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk("to_req_up", dm_req, 1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         chk("to_wait_req", dm_req, 1);
         chk("to_wait_err", err_out, 0);
      end
      @(posedge clk); #1;
      chk("to_err_pulse", err_out, 1);
      chk("to_req_drop", dm_req, 0);
      chk("to_wen", wen_out, 0);
      drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
      #1;
      chk("to_stall", stall_out, 0);
      @(posedge clk); #1;
      chk("to_err_once", err_out, 0);
`else
      // Without the timeout feature a long wait simply persists until ack.
      run_op(1, 0, 1, 0, 1, 5'd9, 32'h200, 32'h0, 32'h0, 32'hCAFE_F00D, 8);
`endif

      // Reset in the middle of a wait
      @(negedge clk);
      drive(1, 0, 1, 0, 1, 5'd12, 32'h300, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk("mr_req_up", dm_req, 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #0.5;
      chk("mr_req_async", dm_req, 0);
      chk("mr_stall", stall_out, 0);
      chk("mr_addr", dm_addr, 0);
      drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
      #0.5;
      rst_n = 1'b1;
      @(negedge clk);
      dm_ack = 1'b1;
      dm_rdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      dm_ack = 1'b0;
      chk("late_ack_req", dm_req, 0);
      chk("late_ack_wen", wen_out, 0);
      chk("late_ack_waddr", waddr_out, 0);
      chk("late_ack_wb", wb_data_out, 0);
      chk("late_ack_err", err_out, 0);
      #1;
      chk("late_ack_stall", stall_out, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
